// File: rtl/gecko_mem_arbiter_pkg.sv
// Shared types for the gecko memory arbiter: request source tag and
// default in-flight depth.
package gecko_mem_arbiter_pkg;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } gecko_mem_source_t;

    localparam int GECKO_MEM_MAX_OUTSTANDING = 4;

    function automatic int gecko_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/std_mem_intf.sv
// Generic valid/ready memory channel used for requests and results.
// The "in" side consumes a channel, the "out" side produces it.
interface std_mem_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic                  write_enable;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport in (
        input  valid, write_enable, read_enable, addr, data,
        output ready
    );

    modport out (
        output valid, write_enable, read_enable, addr, data,
        input  ready
    );
endinterface

// File: rtl/gecko_mem_tag_fifo.sv
// In-order FIFO of request source tags; count is kept separately so
// full/empty stay unambiguous for any depth.
import gecko_mem_arbiter_pkg::*;

module gecko_mem_tag_fifo #(
    parameter int  DEPTH = GECKO_MEM_MAX_OUTSTANDING,
    localparam int PW    = gecko_ptr_width(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  gecko_mem_source_t push_tag,
    input  logic              pop,
    output gecko_mem_source_t head_tag,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    gecko_mem_source_t tags [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign head_tag = tags[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            tags[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/gecko_mem_arbiter.sv
// Round-robin share of one memory port between fetch and data ports;
// results are steered back in order by the source-tag FIFO.
import gecko_mem_arbiter_pkg::*;

module gecko_mem_arbiter #(
    parameter int  ADDR_WIDTH      = 32,
    parameter int  DATA_WIDTH      = 32,
    parameter int  MAX_OUTSTANDING = GECKO_MEM_MAX_OUTSTANDING,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    std_mem_intf.in       inst_request,
    std_mem_intf.out      inst_result,
    std_mem_intf.in       data_request,
    std_mem_intf.out      data_result,
    std_mem_intf.out      mem_request,
    std_mem_intf.in       mem_result,
    output logic [CW-1:0] outstanding,
    output logic          spurious_flag
);
    gecko_mem_source_t     last_grant;
    gecko_mem_source_t     lock_src;
    gecko_mem_source_t     arb_src;
    gecko_mem_source_t     sel;
    gecko_mem_source_t     owner;
    logic                  lock_q;
    logic                  sel_valid;
    logic                  req_fire;
    logic                  res_live;
    logic                  res_fire;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        arb_src = INST;
        unique case ({inst_request.valid, data_request.valid})
            2'b11:   arb_src = (last_grant == DATA) ? INST : DATA;
            2'b01:   arb_src = DATA;
            default: arb_src = INST;
        endcase
    end

    // A stalled request keeps its source until memory takes it.
    assign sel = lock_q ? lock_src : arb_src;

    always_comb begin
        sel_valid = inst_request.valid;
        sel_addr  = inst_request.addr;
        sel_data  = inst_request.data;
        mem_request.write_enable = inst_request.write_enable;
        mem_request.read_enable  = inst_request.read_enable;
        if (sel == DATA) begin
            sel_valid = data_request.valid;
            sel_addr  = data_request.addr;
            sel_data  = data_request.data;
            mem_request.write_enable = data_request.write_enable;
            mem_request.read_enable  = data_request.read_enable;
        end
    end

    assign mem_request.valid = sel_valid && !fifo_full && !rst;
    assign mem_request.addr  = sel_addr;
    assign mem_request.data  = sel_data;
    assign req_fire          = mem_request.valid && mem_request.ready;

    assign inst_request.ready = req_fire && (sel == INST);
    assign data_request.ready = req_fire && (sel == DATA);

    assign res_live = !fifo_empty && !rst;

    assign inst_result.valid = res_live && (owner == INST) && mem_result.valid;
    assign data_result.valid = res_live && (owner == DATA) && mem_result.valid;
    assign inst_result.data  = mem_result.data;
    assign data_result.data  = mem_result.data;
    assign inst_result.addr  = '0;
    assign data_result.addr  = '0;
    assign inst_result.write_enable = 1'b0;
    assign inst_result.read_enable  = 1'b0;
    assign data_result.write_enable = 1'b0;
    assign data_result.read_enable  = 1'b0;

    assign mem_result.ready = res_live &&
        ((owner == DATA) ? data_result.ready : inst_result.ready);
    assign res_fire = mem_result.valid && mem_result.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q        <= 1'b0;
            lock_src      <= DATA;
            last_grant    <= DATA;
            spurious_flag <= 1'b0;
        end else begin
            lock_q <= mem_request.valid && !mem_request.ready;
            if (mem_request.valid) begin
                lock_src <= sel;
            end
            if (req_fire) begin
                last_grant <= sel;
            end
            if (mem_result.valid && fifo_empty) begin
                spurious_flag <= 1'b1;
            end
        end
    end

    gecko_mem_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_fire),
        .push_tag (sel),
        .pop      (res_fire),
        .head_tag (owner),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

endmodule

// File: tb/tb_gecko_mem_arbiter.sv
// Bench for gecko_mem_arbiter: grant table, scoreboarded result routing,
// and hand sequences for full, head blocking, spurious and reset.
import gecko_mem_arbiter_pkg::*;

module tb_gecko_mem_arbiter;

    typedef struct {
        logic              iv;
        logic              dv;
        logic              mr;
        logic              exp_v;
        gecko_mem_source_t exp_src;
        logic              exp_ir;
        logic              exp_dr;
    } vec_t;

    typedef struct {
        gecko_mem_source_t src;
        logic [31:0]       data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  outstanding;
    logic        spurious_flag;

    std_mem_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) inst_req_if ();
    std_mem_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) inst_res_if ();
    std_mem_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) data_req_if ();
    std_mem_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) data_res_if ();
    std_mem_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_req_if ();
    std_mem_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_res_if ();

    gecko_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_request  (inst_req_if),
        .inst_result   (inst_res_if),
        .data_request  (data_req_if),
        .data_result   (data_res_if),
        .mem_request   (mem_req_if),
        .mem_result    (mem_res_if),
        .outstanding   (outstanding),
        .spurious_flag (spurious_flag)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          grants  = 0;
    logic [31:0] inst_addr = 32'h0000_0100;
    logic [31:0] data_addr = 32'h2000_0000;
    logic        mem_hold = 1'b0;
    logic        spur     = 1'b0;
    logic [31:0] mq [$];
    exp_t        sb [$];
    vec_t        vecs [17];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] resp(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic route(input gecko_mem_source_t src, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            chk("route_unexpected", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("route_src", src, e.src);
            chk("route_data", d, e.data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @* begin
        inst_req_if.addr = inst_addr;
        inst_req_if.data = 32'h0;
        data_req_if.addr = data_addr;
        data_req_if.data = data_addr ^ 32'h5555_5555;
    end

    // Monitor: scoreboard push on grant, check on result delivery.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_res_if.valid && mem_res_if.ready && mq.size() > 0)
                void'(mq.pop_front());
            if (mem_req_if.valid && mem_req_if.ready) begin
                mq.push_back(mem_req_if.addr);
                sb.push_back('{src: (mem_req_if.addr[29] ? DATA : INST),
                               data: resp(mem_req_if.addr)});
                grants <= grants + 1;
            end
            if (inst_res_if.valid && inst_res_if.ready)
                route(INST, inst_res_if.data);
            if (data_res_if.valid && data_res_if.ready)
                route(DATA, data_res_if.data);
            if (inst_req_if.valid && inst_req_if.ready)
                inst_addr <= inst_addr + 32'd4;
            if (data_req_if.valid && data_req_if.ready)
                data_addr <= data_addr + 32'd4;
        end
    end

    // Memory model: one in-order result per cycle, one cycle after grant.
    always @(posedge clk) begin
        #2;
        mem_res_if.addr         = 32'h0;
        mem_res_if.write_enable = 1'b0;
        mem_res_if.read_enable  = 1'b0;
        if (spur) begin
            mem_res_if.valid = 1'b1;
            mem_res_if.data  = 32'h5BAD_5BAD;
        end else if (!mem_hold && mq.size() > 0) begin
            mem_res_if.valid = 1'b1;
            mem_res_if.data  = resp(mq[0]);
        end else begin
            mem_res_if.valid = 1'b0;
            mem_res_if.data  = 32'h0;
        end
    end

    initial begin
        int g0;
        logic [31:0] ea;
        vecs[0]  = '{1, 0, 1, 1, INST, 1, 0};
        vecs[1]  = '{1, 1, 1, 1, DATA, 0, 1};
        vecs[2]  = '{1, 1, 1, 1, INST, 1, 0};
        vecs[3]  = '{1, 1, 1, 1, DATA, 0, 1};
        vecs[4]  = '{0, 1, 1, 1, DATA, 0, 1};
        vecs[5]  = '{1, 1, 1, 1, INST, 1, 0};
        vecs[6]  = '{0, 0, 1, 0, INST, 0, 0};
        vecs[7]  = '{1, 1, 0, 1, DATA, 0, 0};
        vecs[8]  = '{1, 1, 0, 1, DATA, 0, 0};
        vecs[9]  = '{1, 1, 0, 1, DATA, 0, 0};
        vecs[10] = '{1, 1, 1, 1, DATA, 0, 1};
        vecs[11] = '{0, 1, 0, 1, DATA, 0, 0};
        vecs[12] = '{1, 1, 0, 1, DATA, 0, 0};
        vecs[13] = '{1, 1, 0, 1, DATA, 0, 0};
        vecs[14] = '{1, 1, 1, 1, DATA, 0, 1};
        vecs[15] = '{1, 1, 1, 1, INST, 1, 0};
        vecs[16] = '{1, 1, 1, 1, DATA, 0, 1};

        rst = 1'b1;
        mem_res_if.valid = 1'b0;
        mem_res_if.data  = 32'h0;
        inst_req_if.valid = 1'b1;
        inst_req_if.read_enable  = 1'b1;
        inst_req_if.write_enable = 1'b0;
        data_req_if.valid = 1'b1;
        data_req_if.read_enable  = 1'b0;
        data_req_if.write_enable = 1'b1;
        mem_req_if.ready  = 1'b1;
        inst_res_if.ready = 1'b1;
        data_res_if.ready = 1'b1;

        @(negedge clk);
        chk("rst_mem_valid", mem_req_if.valid, 0);
        chk("rst_inst_ready", inst_req_if.ready, 0);
        chk("rst_data_ready", data_req_if.ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_spurious", spurious_flag, 0);
        chk("rst_inst_res_valid", inst_res_if.valid, 0);
        chk("rst_data_res_valid", data_res_if.valid, 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            inst_req_if.valid = vecs[i].iv;
            data_req_if.valid = vecs[i].dv;
            mem_req_if.ready  = vecs[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_mem_valid", i), mem_req_if.valid, vecs[i].exp_v);
            chk($sformatf("vec%0d_inst_ready", i), inst_req_if.ready, vecs[i].exp_ir);
            chk($sformatf("vec%0d_data_ready", i), data_req_if.ready, vecs[i].exp_dr);
            if (vecs[i].exp_v) begin
                ea = (vecs[i].exp_src == DATA) ? data_addr : inst_addr;
                chk($sformatf("vec%0d_addr", i), mem_req_if.addr, ea);
                chk($sformatf("vec%0d_data", i), mem_req_if.data,
                    (vecs[i].exp_src == DATA) ? ea ^ 32'h5555_5555 : 32'h0);
                chk($sformatf("vec%0d_we", i), mem_req_if.write_enable,
                    vecs[i].exp_src == DATA);
            end
            step();
        end

        inst_req_if.valid = 1'b0;
        data_req_if.valid = 1'b0;
        mem_req_if.ready  = 1'b1;
        repeat (4) step();
        chk("drain_outstanding", outstanding, 0);
        chk("drain_sb", sb.size(), 0);

        // Full: four grants, then blocked even while a pop happens.
        mem_hold = 1'b1;
        inst_req_if.valid = 1'b1;
        g0 = grants;
        repeat (6) step();
        chk("full_grants", grants - g0, 4);
        @(negedge clk);
        chk("full_outstanding", outstanding, 4);
        chk("full_mem_valid", mem_req_if.valid, 0);
        chk("full_inst_ready", inst_req_if.ready, 0);
        step();
        mem_hold = 1'b0;
        @(negedge clk);
        chk("pop_mem_res_ready", mem_res_if.ready, 1);
        chk("pop_outstanding", outstanding, 4);
        chk("pop_no_bypass", mem_req_if.valid, 0);
        step();
        mem_hold = 1'b1;
        @(negedge clk);
        chk("after_pop_outstanding", outstanding, 3);
        chk("after_pop_grant", mem_req_if.valid, 1);
        step();
        @(negedge clk);
        chk("refill_outstanding", outstanding, 4);
        step();
        inst_req_if.valid = 1'b0;
        mem_hold = 1'b0;
        repeat (8) step();
        chk("full_drain", outstanding, 0);

        // DATA at FIFO head with data_result stalled blocks INST result.
        mem_hold = 1'b1;
        data_req_if.valid = 1'b1;
        step();
        data_req_if.valid = 1'b0;
        inst_req_if.valid = 1'b1;
        step();
        inst_req_if.valid = 1'b0;
        data_res_if.ready = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        chk("hol_outstanding", outstanding, 2);
        chk("hol_data_valid", data_res_if.valid, 1);
        chk("hol_mem_ready", mem_res_if.ready, 0);
        chk("hol_inst_valid", inst_res_if.valid, 0);
        step();
        step();
        @(negedge clk);
        chk("hol2_mem_ready", mem_res_if.ready, 0);
        chk("hol2_inst_valid", inst_res_if.valid, 0);
        step();
        data_res_if.ready = 1'b1;
        @(negedge clk);
        chk("hol_release_ready", mem_res_if.ready, 1);
        step();
        @(negedge clk);
        chk("hol_inst_follows", inst_res_if.valid, 1);
        chk("hol_outstanding1", outstanding, 1);
        step();
        step();
        chk("hol_drain", outstanding, 0);

        // Result with nothing in flight.
        spur = 1'b1;
        @(negedge clk);
        chk("spur_mem_ready", mem_res_if.ready, 0);
        chk("spur_inst_valid", inst_res_if.valid, 0);
        chk("spur_data_valid", data_res_if.valid, 0);
        step();
        spur = 1'b0;
        @(negedge clk);
        chk("spur_flag_set", spurious_flag, 1);
        step();
        step();
        chk("spur_flag_sticky", spurious_flag, 1);

        // Reset in the middle of a burst.
        mem_hold = 1'b1;
        inst_req_if.valid = 1'b1;
        data_req_if.valid = 1'b1;
        step();
        step();
        chk("burst_outstanding", outstanding, 2);
        rst = 1'b1;
        mq.delete();
        sb.delete();
        #1;
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_mem_valid", mem_req_if.valid, 0);
        chk("midrst_inst_ready", inst_req_if.ready, 0);
        chk("midrst_data_ready", data_req_if.ready, 0);
        chk("midrst_spurious", spurious_flag, 0);
        step();
        rst = 1'b0;
        inst_req_if.valid = 1'b0;
        data_req_if.valid = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        chk("postrst_outstanding", outstanding, 0);
        step();
        spur = 1'b1;
        @(negedge clk);
        chk("postrst_mem_ready", mem_res_if.ready, 0);
        step();
        spur = 1'b0;
        @(negedge clk);
        chk("postrst_spurious", spurious_flag, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
